// File: rtl/gpio_led_sequencer.sv
// gpio_led_sequencer
//   LED pattern engine for the board GPIO LED bank. A prescaler divides clk
//   down to a step rate. Each step advances a position counter whose meaning
//   depends on the registered mode. GPIO_LED is decoded combinationally from
//   (mode_q, pos), so it changes on the same edge that raises step.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low
//   enable    1 = run, 0 = pause (all state held, no pulses)
//   mode      0 rotate-left, 1 rotate-right, 2 bounce, 3 bar-fill
//   GPIO_LED  LED drive, bit 0 = LED 0, active-high
//   step      one-cycle pulse aligned with each new pattern value
//   wrap      one-cycle pulse with step when the new position is 0
module gpio_led_sequencer #(
  parameter int LED_W    = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] GPIO_LED,
  output logic             step,
  output logic             wrap
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = $clog2(LED_W + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_TOP  = PW'(LED_W - 1);
  localparam logic [PW-1:0] POS_FULL = PW'(LED_W);

  localparam logic [1:0] M_ROTL = 2'd0;
  localparam logic [1:0] M_ROTR = 2'd1;
  localparam logic [1:0] M_BNC  = 2'd2;
  localparam logic [1:0] M_FILL = 2'd3;

  logic [CW-1:0] cnt;
  logic [PW-1:0] pos, pos_nxt;
  logic          dir_dn, dir_nxt;
  logic [1:0]    mode_q;
  logic          tick;

  assign tick = enable && (cnt == CNT_MAX);

  // Next position / direction for a step in the current mode.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir_dn;
    case (mode_q)
      M_BNC: begin
        if (!dir_dn) begin
          pos_nxt = pos + 1'b1;
          if (pos_nxt == POS_TOP) dir_nxt = 1'b1;
        end else begin
          pos_nxt = pos - 1'b1;
          if (pos_nxt == '0) dir_nxt = 1'b0;
        end
      end
      // Bar-fill has LED_W+1 states: empty through full.
      M_FILL:  pos_nxt = (pos == POS_FULL) ? '0 : pos + 1'b1;
      default: pos_nxt = (pos == POS_TOP)  ? '0 : pos + 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      pos    <= '0;
      dir_dn <= 1'b0;
      mode_q <= M_ROTL;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else if (mode != mode_q) begin
      // A mode change restarts the pattern and the prescale period; it
      // wins over a coincident tick and is taken even while paused.
      mode_q <= mode;
      cnt    <= '0;
      pos    <= '0;
      dir_dn <= 1'b0;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else if (tick) begin
      cnt    <= '0;
      pos    <= pos_nxt;
      dir_dn <= dir_nxt;
      step   <= 1'b1;
      wrap   <= (pos_nxt == '0);
    end else begin
      if (enable) cnt <= cnt + 1'b1;
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // Per-LED decode of the current position.
  for (genvar i = 0; i < LED_W; i++) begin : g_led
    localparam logic [PW-1:0] IDX = PW'(i);
    localparam logic [PW-1:0] REV = PW'(LED_W - 1 - i);
    assign GPIO_LED[i] = (mode_q == M_ROTR) ? (pos == REV) :
                         (mode_q == M_FILL) ? (IDX < pos)  :
                                              (pos == IDX);
  end

endmodule

// File: tb/tb_gpio_led_sequencer.sv
module tb_gpio_led_sequencer;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic       wrap;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0, enable1 = 1'b0;
  logic [1:0] mode = 2'd0, mode1 = 2'd0;
  logic [7:0] led, led1;
  logic       step, wrap, step1, wrap1;

  int cyc = 0;
  int nchk_sb = 0, npass_sb = 0;
  int nchk_d  = 0, npass_d  = 0;
  sb_t q[$], q1[$];
  sb_t e, e1;

  gpio_led_sequencer #(.LED_W(8), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .GPIO_LED(led), .step(step), .wrap(wrap)
  );

  gpio_led_sequencer #(.LED_W(8), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .mode(mode1),
    .GPIO_LED(led1), .step(step1), .wrap(wrap1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every step/wrap pulse must match the head entry
  // (cycle, pattern, wrap); entries whose cycle passed unseen are misses.
  always @(negedge clk) begin
    if (step || wrap) begin
      nchk_sb++;
      if (q.size() == 0)
        $display("FAIL sb_unexpected cyc=%0d led=%h step=%b wrap=%b", cyc, led, step, wrap);
      else begin
        e = q.pop_front();
        if (step && e.cyc == cyc && e.led == led && e.wrap == wrap) npass_sb++;
        else $display("FAIL sb_step got cyc=%0d led=%h step=%b wrap=%b want cyc=%0d led=%h wrap=%b",
                      cyc, led, step, wrap, e.cyc, e.led, e.wrap);
      end
    end else
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        nchk_sb++;
        $display("FAIL sb_missed want cyc=%0d led=%h, no step seen (now cyc=%0d led=%h)", e.cyc, e.led, cyc, led);
      end
    if (step1 || wrap1) begin
      nchk_sb++;
      if (q1.size() == 0)
        $display("FAIL sb1_unexpected cyc=%0d led=%h step=%b wrap=%b", cyc, led1, step1, wrap1);
      else begin
        e1 = q1.pop_front();
        if (step1 && e1.cyc == cyc && e1.led == led1 && e1.wrap == wrap1) npass_sb++;
        else $display("FAIL sb1_step got cyc=%0d led=%h step=%b wrap=%b want cyc=%0d led=%h wrap=%b",
                      cyc, led1, step1, wrap1, e1.cyc, e1.led, e1.wrap);
      end
    end else
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
        e1 = q1.pop_front();
        nchk_sb++;
        $display("FAIL sb1_missed want cyc=%0d led=%h (now cyc=%0d led=%h)", e1.cyc, e1.led, cyc, led1);
      end
  end

  task automatic at(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk_d++;
    if (act === exp) npass_d++;
    else $display("FAIL %s got %h want %h (cyc=%0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int c, input int l, input bit w);
    q.push_back('{c, 8'(l), w});
  endtask

  int R, N1, N2, N3, N4, N5, M, p;

  initial begin
    // Reset state.
    at(3);
    chk("rst_led", 32'(led), 32'h01);
    chk("rst_step", 32'(step), 0);
    chk("rst_wrap", 32'(wrap), 0);

    // Rotate-left.
    R = 3;
    reset = 1'b1; enable = 1'b1;
    chk("rotl_start", 32'(led), 32'h01);
    for (int k = 1; k <= 8; k++) push(R + 4*k, 1 << (k % 8), k == 8);

    // Rotate-right.
    N1 = R + 32; at(N1); mode = 2'd1;
    at(N1 + 1);
    chk("rotr_start", 32'(led), 32'h80);
    chk("modechg_step", 32'(step), 0);
    for (int k = 1; k <= 8; k++) push(N1 + 1 + 4*k, 128 >> (k % 8), k == 8);

    // Bounce: 0..7 then 6..0, 14 steps.
    N2 = N1 + 33; at(N2); mode = 2'd2;
    at(N2 + 1);
    chk("bnc_start", 32'(led), 32'h01);
    for (int k = 1; k <= 14; k++) begin
      p = (k <= 7) ? k : 14 - k;
      push(N2 + 1 + 4*k, 1 << p, k == 14);
    end

    // Bar-fill: 9 steps.
    N3 = N2 + 57; at(N3); mode = 2'd3;
    at(N3 + 1);
    chk("fill_start", 32'(led), 32'h00);
    for (int k = 1; k <= 9; k++) push(N3 + 1 + 4*k, (1 << (k % 9)) - 1, k == 9);

    // Pause mid-sequence at 0x10.
    N4 = N3 + 37; at(N4); mode = 2'd0;
    at(N4 + 1);
    chk("rotl2_start", 32'(led), 32'h01);
    for (int k = 1; k <= 4; k++) push(N4 + 1 + 4*k, 1 << k, 1'b0);
    at(N4 + 18); enable = 1'b0;      // prescaler is at 1
    for (int i = 0; i < 10; i++) begin
      at(N4 + 19 + i);
      chk("pause_led", 32'(led), 32'h10);
      chk("pause_step", 32'(step), 0);
    end
    enable = 1'b1;
    push(N4 + 31, 8'h20, 1'b0);      // 3 remaining prescale counts

    // Pause exactly on the terminal count.
    at(N4 + 34); enable = 1'b0;
    push(N4 + 38, 8'h40, 1'b0);
    at(N4 + 37); enable = 1'b1;

    // Mode 0 -> 3 mid-period: clears pattern, restarts prescaler.
    at(N4 + 40); mode = 2'd3;
    at(N4 + 41);
    chk("chg_fill_led", 32'(led), 32'h00);
    chk("chg_fill_step", 32'(step), 0);
    chk("chg_fill_wrap", 32'(wrap), 0);
    push(N4 + 45, 8'h01, 1'b0);

    // Async reset while bounce is descending.
    N5 = N4 + 45; at(N5); mode = 2'd2;
    for (int k = 1; k <= 9; k++) begin
      p = (k <= 7) ? k : 14 - k;
      push(N5 + 1 + 4*k, 1 << p, 1'b0);
    end
    at(N5 + 39);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'h01);
    chk("async_rst_step", 32'(step), 0);
    chk("async_rst_wrap", 32'(wrap), 0);
    at(N5 + 40); reset = 1'b1;
    // mode_q returned to 0, so mode=2 is re-applied; bounce restarts upward.
    push(N5 + 45, 8'h02, 1'b0);
    push(N5 + 49, 8'h04, 1'b0);
    at(N5 + 50); enable = 1'b0;

    // TICK_DIV=1: steps every enabled clock.
    M = N5 + 51; at(M); enable1 = 1'b1;
    for (int k = 1; k <= 10; k++) q1.push_back('{M + k, 8'(1 << (k % 8)), (k % 8) == 0});
    at(M + 10); enable1 = 1'b0;

    at(M + 14);
    chk("sb_drained", 32'(q.size()), 0);
    chk("sb1_drained", 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", npass_d + npass_sb, nchk_d + nchk_sb);
    $finish;
  end

endmodule
